// File: rtl/ball_engine_if.sv
// rtl/ball_engine_if.sv - scan, paddle and serve inputs plus ball/score outputs of the ball engine
interface ball_engine_if #(
   parameter int SCORE_W = 4
);
   logic               start;
   logic [7:0]         xCount;
   logic [8:0]         yCount;
   logic [7:0]         paddleX0;
   logic [7:0]         paddleX1;
   logic               drawBall;
   logic [7:0]         ballX;
   logic [8:0]         ballY;
   logic [SCORE_W-1:0] score0;
   logic [SCORE_W-1:0] score1;
   logic               gameOver;
   logic               hit;

   // Game side: drives serve request, scan position and paddles.
   modport master (
      output start, xCount, yCount, paddleX0, paddleX1,
      input  drawBall, ballX, ballY, score0, score1, gameOver, hit
   );

   // Engine side.
   modport slave (
      input  start, xCount, yCount, paddleX0, paddleX1,
      output drawBall, ballX, ballY, score0, score1, gameOver, hit
   );
endinterface

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - Pong ball engine: motion, paddle reflection, scoring and ball pixel hit
module ball_engine #(
   parameter int WIDTH       = 240,
   parameter int HEIGHT      = 320,
   parameter int PADDLE_SIZE = 40,
   parameter int BALL_SIZE   = 2,
   parameter int PADDLE_ROW0 = 5,
   parameter int PADDLE_ROW1 = HEIGHT - 6,
   parameter int TICK_START  = 350000,
   parameter int TICK_STEP   = 20000,
   parameter int TICK_MIN    = 100000,
   parameter int SERVE_DELAY = 25000000,
   parameter int MAX_SCORE   = 9,
   parameter int SCORE_W     = 4
) (
   input  logic         clock,
   input  logic         reset,
   ball_engine_if.slave bus
);

   localparam int TICK_W  = $clog2(TICK_START + 1);
   localparam int DELAY_W = $clog2(SERVE_DELAY + 1);

   localparam logic [7:0]         CENTRE_X   = 8'(WIDTH / 2);
   localparam logic [8:0]         CENTRE_Y   = 9'(HEIGHT / 2);
   localparam logic [7:0]         X_LAST     = 8'(WIDTH - 2);
   localparam logic [8:0]         Y_LAST     = 9'(HEIGHT - 1);
   localparam logic [8:0]         ROW0       = 9'(PADDLE_ROW0);
   localparam logic [8:0]         ROW1       = 9'(PADDLE_ROW1);
   localparam logic [8:0]         PAD_LEN    = 9'(PADDLE_SIZE);
   localparam logic [8:0]         HALF_X     = 9'(BALL_SIZE);
   localparam logic [9:0]         HALF_Y     = 10'(BALL_SIZE);
   localparam logic [TICK_W-1:0]  PERIOD_0   = TICK_W'(TICK_START);
   localparam logic [TICK_W-1:0]  PERIOD_DEC = TICK_W'(TICK_STEP);
   localparam logic [TICK_W-1:0]  PERIOD_MIN = TICK_W'(TICK_MIN);
   localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(SERVE_DELAY - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

   typedef enum logic [1:0] {SERVE, PLAY, SCORED, GAMEOVER} state_t;

   state_t               state;
   logic [7:0]           ball_x;
   logic [8:0]           ball_y;
   logic                 dir_x;      // 1 = right
   logic                 dir_y;      // 1 = down
   logic                 last_loser; // 1 = bottom player lost the point
   logic [TICK_W-1:0]    period;
   logic [TICK_W-1:0]    tick_cnt;
   logic [DELAY_W-1:0]   delay_cnt;
   logic [SCORE_W-1:0]   score0;
   logic [SCORE_W-1:0]   score1;
   logic                 game_over;
   logic                 hit_pulse;
   logic                 draw;

   logic [8:0]           x_wide;
   logic                 on_pad0;
   logic                 on_pad1;
   logic [7:0]           x_next;
   logic [8:0]           y_next;
   logic                 dir_x_next;
   logic                 dir_y_next;
   logic                 step_hit;
   logic                 miss_top;
   logic                 miss_bottom;
   logic [TICK_W-1:0]    period_next;
   logic                 step_now;

   // Paddle spans are compared in 9 bits so paddle edge + length cannot wrap.
   assign x_wide  = {1'b0, ball_x};
   assign on_pad0 = (x_wide >= {1'b0, bus.paddleX0}) && (x_wide <= ({1'b0, bus.paddleX0} + PAD_LEN));
   assign on_pad1 = (x_wide >= {1'b0, bus.paddleX1}) && (x_wide <= ({1'b0, bus.paddleX1} + PAD_LEN));

   // Faster play after a hit, clamped at the floor without ever going below zero.
   assign period_next = (32'(period) >= 32'(TICK_MIN + TICK_STEP)) ? (period - PERIOD_DEC) : PERIOD_MIN;
   assign step_now    = (tick_cnt == (period - 1'b1));

   // One move step computed from the current position and direction.
   always_comb begin
      y_next      = ball_y;
      dir_y_next  = dir_y;
      step_hit    = 1'b0;
      miss_top    = 1'b0;
      miss_bottom = 1'b0;
      if (!dir_y && (ball_y == ROW0) && on_pad0) begin
         dir_y_next = 1'b1;
         y_next     = ball_y + 1'b1;
         step_hit   = 1'b1;
      end else if (dir_y && (ball_y == ROW1) && on_pad1) begin
         dir_y_next = 1'b0;
         y_next     = ball_y - 1'b1;
         step_hit   = 1'b1;
      end else if (!dir_y && (ball_y == 9'd0)) begin
         miss_top = 1'b1;
      end else if (dir_y && (ball_y == Y_LAST)) begin
         miss_bottom = 1'b1;
      end else if (dir_y) begin
         y_next = ball_y + 1'b1;
      end else begin
         y_next = ball_y - 1'b1;
      end

      dir_x_next = dir_x;
      if (!dir_x && (ball_x == 8'd1)) begin
         dir_x_next = 1'b1;
      end else if (dir_x && (ball_x == X_LAST)) begin
         dir_x_next = 1'b0;
      end
      x_next = dir_x_next ? (ball_x + 1'b1) : (ball_x - 1'b1);
   end

   // Game state machine owning ball position, direction, speed, scores and flags.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= SERVE;
         ball_x     <= CENTRE_X;
         ball_y     <= CENTRE_Y;
         dir_x      <= 1'b1;
         dir_y      <= 1'b1;
         last_loser <= 1'b0;
         period     <= PERIOD_0;
         tick_cnt   <= '0;
         delay_cnt  <= '0;
         score0     <= '0;
         score1     <= '0;
         game_over  <= 1'b0;
         hit_pulse  <= 1'b0;
      end else begin
         hit_pulse <= 1'b0;
         case (state)
            SERVE: begin
               if (bus.start) begin
                  state    <= PLAY;
                  tick_cnt <= '0;
               end
            end
            PLAY: begin
               if (step_now) begin
                  tick_cnt  <= '0;
                  ball_x    <= x_next;
                  dir_x     <= dir_x_next;
                  ball_y    <= y_next;
                  dir_y     <= dir_y_next;
                  hit_pulse <= step_hit;
                  if (step_hit) begin
                     period <= period_next;
                  end
                  if (miss_top) begin
                     score1     <= (score1 == SCORE_MAX) ? score1 : (score1 + 1'b1);
                     last_loser <= 1'b0;
                     delay_cnt  <= '0;
                     state      <= SCORED;
                  end
                  if (miss_bottom) begin
                     score0     <= (score0 == SCORE_MAX) ? score0 : (score0 + 1'b1);
                     last_loser <= 1'b1;
                     delay_cnt  <= '0;
                     state      <= SCORED;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            SCORED: begin
               if (delay_cnt == DELAY_LAST) begin
                  ball_x   <= CENTRE_X;
                  ball_y   <= CENTRE_Y;
                  period   <= PERIOD_0;
                  tick_cnt <= '0;
                  if ((score0 == SCORE_MAX) || (score1 == SCORE_MAX)) begin
                     state     <= GAMEOVER;
                     game_over <= 1'b1;
                  end else begin
                     state <= SERVE;
                     dir_y <= last_loser;
                  end
               end else begin
                  delay_cnt <= delay_cnt + 1'b1;
               end
            end
            GAMEOVER: begin
               if (bus.start) begin
                  score0    <= '0;
                  score1    <= '0;
                  game_over <= 1'b0;
                  state     <= SERVE;
               end
            end
            default: state <= SERVE;
         endcase
      end
   end

   // Ball pixel hit for the scan position, written so nothing underflows near 0.
   always_ff @(posedge clock) begin
      if (!reset) begin
         draw <= 1'b0;
      end else begin
         draw <= (({1'b0, bus.yCount} + HALF_Y) >= {1'b0, ball_y}) &&
                 ({1'b0, bus.yCount} <= ({1'b0, ball_y} + HALF_Y)) &&
                 (({1'b0, bus.xCount} + HALF_X) >= x_wide) &&
                 ({1'b0, bus.xCount} <= (x_wide + HALF_X));
      end
   end

   assign bus.drawBall = draw;
   assign bus.ballX    = ball_x;
   assign bus.ballY    = ball_y;
   assign bus.score0   = score0;
   assign bus.score1   = score1;
   assign bus.gameOver = game_over;
   assign bus.hit      = hit_pulse;

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - self-checking bench for ball_engine with a behavioural reference model
module tb_ball_engine;
   localparam int W = 240, H = 320, PS = 40, BS = 2, R0 = 5, R1 = H - 6;
   localparam int TS = 10, TSTEP = 4, TMIN = 4, SD = 30, MAXS = 2, SW = 4;
   localparam int LIMIT = 20000;

   logic clock = 1'b0;
   logic reset = 1'b0;

   ball_engine_if #(.SCORE_W(SW)) bus ();

   ball_engine #(
      .WIDTH(W), .HEIGHT(H), .PADDLE_SIZE(PS), .BALL_SIZE(BS),
      .PADDLE_ROW0(R0), .PADDLE_ROW1(R1), .TICK_START(TS), .TICK_STEP(TSTEP),
      .TICK_MIN(TMIN), .SERVE_DELAY(SD), .MAX_SCORE(MAXS), .SCORE_W(SW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] x;
      logic [8:0] y;
      bit         exp;
   } draw_vec_t;

   int tests = 0;
   int fails = 0;

   // Reference model: 0 serve, 1 play, 2 scored, 3 game over
   int m_state, mx, my, mdx, mdy, m_period, m_tick, m_delay, m_s0, m_s1, m_loser, m_hits;
   bit m_hit, m_go;
   bit draw_q[$];
   int pad_mode0 = 0, pad_mode1 = 0; // 0 fixed, 1 track ball, 2 keep away

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic model_reset();
      m_state = 0; mx = W / 2; my = H / 2; mdx = 1; mdy = 1;
      m_period = TS; m_tick = 0; m_delay = 0; m_s0 = 0; m_s1 = 0;
      m_loser = 0; m_hit = 0; m_go = 0; m_hits = 0;
   endtask

   function automatic bit draw_model(input int x, input int y);
      return (y - my <= BS) && (my - y <= BS) && (x - mx <= BS) && (mx - x <= BS);
   endfunction

   task automatic model_clock(input bit rst, input bit st, input int p0, input int p1);
      int ny;
      m_hit = 0;
      if (!rst) begin
         model_reset();
         return;
      end
      case (m_state)
         0: if (st) begin m_state = 1; m_tick = 0; end
         1: begin
            if (m_tick == m_period - 1) begin
               m_tick = 0;
               ny = my;
               if (mdy < 0 && my == R0 && mx >= p0 && mx <= p0 + PS) begin
                  mdy = 1; ny = my + 1; m_hit = 1;
               end else if (mdy > 0 && my == R1 && mx >= p1 && mx <= p1 + PS) begin
                  mdy = -1; ny = my - 1; m_hit = 1;
               end else if (mdy < 0 && my == 0) begin
                  if (m_s1 < MAXS) m_s1++;
                  m_state = 2; m_loser = 0; m_delay = 0;
               end else if (mdy > 0 && my == H - 1) begin
                  if (m_s0 < MAXS) m_s0++;
                  m_state = 2; m_loser = 1; m_delay = 0;
               end else begin
                  ny = my + mdy;
               end
               if ((mdx < 0 && mx == 1) || (mdx > 0 && mx == W - 2)) mdx = -mdx;
               mx = mx + mdx;
               my = ny;
               if (m_hit) begin
                  m_hits++;
                  m_period = (m_period - TSTEP < TMIN) ? TMIN : m_period - TSTEP;
               end
            end else begin
               m_tick++;
            end
         end
         2: begin
            if (m_delay == SD - 1) begin
               mx = W / 2; my = H / 2; m_period = TS; m_tick = 0;
               if (m_s0 == MAXS || m_s1 == MAXS) begin
                  m_state = 3; m_go = 1;
               end else begin
                  m_state = 0; mdy = m_loser ? 1 : -1;
               end
            end else begin
               m_delay++;
            end
         end
         default: if (st) begin m_s0 = 0; m_s1 = 0; m_state = 0; m_go = 0; end
      endcase
   endtask

   function automatic int paddle_for(input int mode, input int cur);
      int p;
      if (mode == 1) begin
         p = mx - PS / 2;
         if (p < 0) p = 0;
         if (p > 255 - PS) p = 255 - PS;
         return p;
      end
      if (mode == 2) return (mx < W / 2) ? 200 : 0;
      return cur;
   endfunction

   // One clock: set paddles, record expectations at the edge, compare at the falling edge.
   task automatic cycle(input int exp_draw);
      bit e;
      bus.paddleX0 = 8'(paddle_for(pad_mode0, int'(bus.paddleX0)));
      bus.paddleX1 = 8'(paddle_for(pad_mode1, int'(bus.paddleX1)));
      @(posedge clock);
      if (!reset) e = 0;
      else if (exp_draw < 0) e = draw_model(int'(bus.xCount), int'(bus.yCount));
      else e = exp_draw[0];
      draw_q.push_back(e);
      model_clock(reset, bus.start, int'(bus.paddleX0), int'(bus.paddleX1));
      @(negedge clock);
      if (draw_q.size() == 0) begin
         timeout_fail("draw_queue_empty");
      end else begin
         e = draw_q.pop_front();
         check("drawBall", int'(bus.drawBall), int'(e));
      end
      check("ballX", int'(bus.ballX), mx);
      check("ballY", int'(bus.ballY), my);
      check("score0", int'(bus.score0), m_s0);
      check("score1", int'(bus.score1), m_s1);
      check("gameOver", int'(bus.gameOver), int'(m_go));
      check("hit", int'(bus.hit), int'(m_hit));
   endtask

   task automatic drive(input int x, input int y, input int exp);
      bus.xCount = 8'(x);
      bus.yCount = 9'(y);
      cycle(exp);
   endtask

   task automatic aim_scan();
      int xs, ys;
      xs = mx + int'($urandom_range(0, 8)) - 4;
      ys = my + int'($urandom_range(0, 8)) - 4;
      if (xs < 0) xs = 0;
      if (ys < 0) ys = 0;
      bus.xCount = 8'(xs);
      bus.yCount = 9'(ys);
   endtask

   draw_vec_t tbl[10];

   initial begin
      int prev, gap, edge_y;
      bit edge_done;

      tbl[0] = '{8'd120, 9'd160, 1'b1};
      tbl[1] = '{8'd118, 9'd158, 1'b1};
      tbl[2] = '{8'd122, 9'd162, 1'b1};
      tbl[3] = '{8'd117, 9'd160, 1'b0};
      tbl[4] = '{8'd123, 9'd160, 1'b0};
      tbl[5] = '{8'd120, 9'd157, 1'b0};
      tbl[6] = '{8'd120, 9'd163, 1'b0};
      tbl[7] = '{8'd0,   9'd0,   1'b0};
      tbl[8] = '{8'd255, 9'd511, 1'b0};
      tbl[9] = '{8'd121, 9'd159, 1'b1};

      model_reset();
      bus.start = 0; bus.xCount = 0; bus.yCount = 0;
      bus.paddleX0 = 8'd30; bus.paddleX1 = 8'd30;

      // Reset, then idle in SERVE with a raster sweep around the centre
      for (int i = 0; i < 3; i++) cycle(-1);
      reset = 1;
      for (int i = 0; i < 100; i++) drive(110 + (i % 20), 150 + (i / 5), -1);
      check("rst_ballX", int'(bus.ballX), 120);
      check("rst_ballY", int'(bus.ballY), 160);
      check("rst_score0", int'(bus.score0), 0);

      // Centre draw vectors
      for (int i = 0; i < 10; i++) drive(int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].exp));

      // Serve: first step lands on the TS-th PLAY clock
      bus.start = 1; cycle(-1); bus.start = 0;
      for (int i = 0; i < TS - 1; i++) cycle(-1);
      check("serve_hold_y", int'(bus.ballY), 160);
      cycle(-1);
      check("serve_step_y", int'(bus.ballY), 161);
      check("serve_step_x", int'(bus.ballX), 121);

      // Reset in the middle of play
      for (int i = 0; i < 15; i++) cycle(-1);
      reset = 0; cycle(-1); reset = 1;
      check("midrst_ballX", int'(bus.ballX), 120);
      check("midrst_ballY", int'(bus.ballY), 160);
      check("midrst_hit", int'(bus.hit), 0);

      // Rally with tracking paddles; probe draw edges while the ball sits at x=1
      pad_mode0 = 1; pad_mode1 = 1;
      bus.start = 1; cycle(-1); bus.start = 0;
      edge_done = 0;
      for (int n = 0; n < LIMIT && m_hits < 3; n++) begin
         if (!edge_done && m_state == 1 && mx == 1 && m_tick == 0) begin
            edge_y = my;
            drive(0, edge_y, 1);
            drive(4, edge_y, 0);
            drive(1, edge_y + 2, 1);
            drive(1, edge_y + 3, 0);
            edge_done = 1;
         end else begin
            aim_scan();
            cycle(-1);
         end
      end
      if (m_hits < 3) timeout_fail("three_hits");
      if (!edge_done) timeout_fail("ball_at_x1");

      // Period after three hits sits at the floor
      prev = int'(bus.ballY);
      for (int n = 0; n < 100 && int'(bus.ballY) == prev; n++) cycle(-1);
      prev = int'(bus.ballY);
      gap = 0;
      for (int n = 0; n < 100 && int'(bus.ballY) == prev; n++) begin cycle(-1); gap++; end
      check("floor_period", gap, TMIN);

      // Bottom miss
      pad_mode1 = 2;
      for (int n = 0; n < LIMIT && m_state != 2; n++) begin aim_scan(); cycle(-1); end
      if (m_state != 2) timeout_fail("reach_scored");
      check("miss_score0", int'(bus.score0), 1);
      check("miss_exit_y", int'(bus.ballY), H - 1);
      for (int n = 0; n < LIMIT && m_state != 0; n++) cycle(-1);
      if (m_state != 0) timeout_fail("reach_serve");
      for (int i = 0; i < 30; i++) cycle(-1);
      check("wait_ballY", int'(bus.ballY), 160);
      check("wait_ballX", int'(bus.ballX), 120);
      bus.start = 1; cycle(-1); bus.start = 0;
      for (int i = 0; i < TS; i++) cycle(-1);
      check("resv_down_y", int'(bus.ballY), 161);

      // Second bottom miss with start held: ignored until GAMEOVER
      bus.start = 1;
      for (int n = 0; n < LIMIT && m_state != 3; n++) begin aim_scan(); cycle(-1); end
      if (m_state != 3) timeout_fail("reach_gameover");
      check("go_flag", int'(bus.gameOver), 1);
      check("go_score0", int'(bus.score0), MAXS);
      check("go_centre_y", int'(bus.ballY), 160);
      cycle(-1);
      bus.start = 0;
      check("restart_score0", int'(bus.score0), 0);
      check("restart_flag", int'(bus.gameOver), 0);
      for (int i = 0; i < 5; i++) cycle(-1);

      // Top miss scores for the bottom player
      pad_mode0 = 2; pad_mode1 = 1;
      bus.start = 1; cycle(-1); bus.start = 0;
      for (int n = 0; n < LIMIT && m_state != 2; n++) begin aim_scan(); cycle(-1); end
      if (m_state != 2) timeout_fail("reach_top_miss");
      check("top_score1", int'(bus.score1), 1);
      check("top_exit_y", int'(bus.ballY), 0);
      for (int i = 0; i < SD + 2; i++) cycle(-1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
